// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU; most ops finish in one cycle, MUL/DIV iterate for W cycles.
// The result is presented only in DONE, so no partial value is ever visible.
module seq_alu #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  input  logic [3:0]     i_op,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic [2*W-1:0] o_result,
  output logic           o_carry,
  output logic           o_zero,
  output logic           o_dbz
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  state_t r_state, w_next;
  logic [W-1:0] r_a, r_b, r_hi, r_lo, w_lo;
  logic [W:0] w_sum, w_rem, w_diff;
  logic [5:0] r_cnt;
  logic r_div, r_carry, r_dbz, w_carry, w_acc, w_long, w_last, w_ge;
  assign w_long = (i_op == OP_MUL) || (i_op == OP_DIV);
  assign w_last = (r_cnt == 6'(W-1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    o_in_ready = (r_state == IDLE);
    o_out_valid = (r_state == DONE);
    w_acc = i_in_valid && o_in_ready;
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_acc ? (w_long ? BUSY : DONE) : IDLE;
      BUSY: w_next = w_last ? DONE : BUSY;
      DONE: w_next = i_out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  // Single-cycle results; for MUL/DIV this seeds the low half of the iteration register.
  always_comb begin
    w_lo = '0;
    w_carry = 1'b0;
    case (i_op)
      4'h0: {w_carry, w_lo} = {1'b0, i_a} + {1'b0, i_b};
      4'h1: begin w_lo = i_a - i_b; w_carry = i_a < i_b; end
      4'h2: w_lo = i_b;
      4'h3: w_lo = i_a;
      4'h4: {w_carry, w_lo} = {i_a, 1'b0};
      4'h5: {w_lo, w_carry} = {1'b0, i_a};
      4'h6: w_lo = {i_a[W-2:0], i_a[W-1]};
      4'h7: w_lo = {i_a[0], i_a[W-1:1]};
      4'h8: w_lo = i_a & i_b;
      4'h9: w_lo = i_a | i_b;
      4'hA: w_lo = i_a ^ i_b;
      4'hB: w_lo = ~(i_a | i_b);
      4'hC: w_lo = ~(i_a & i_b);
      4'hD: w_lo = ~(i_a ^ i_b);
      4'hE: w_lo = W'(i_a > i_b);
      4'hF: w_lo = W'(i_a == i_b);
    endcase
  end
  // {r_hi, r_lo}: partial product / multiplier for MUL, remainder / quotient for DIV.
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_rem = {r_hi, r_lo[W-1]};
  assign w_diff = w_rem - {1'b0, r_b};
  assign w_ge = !w_diff[W];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_cnt <= '0;
      r_div <= 1'b0;
      r_carry <= 1'b0;
      r_dbz <= 1'b0;
    end else if (w_acc) begin
      r_a <= i_a;
      r_b <= i_b;
      r_hi <= '0;
      r_lo <= w_lo;
      r_cnt <= '0;
      r_div <= (i_op == OP_DIV);
      r_carry <= w_carry;
      r_dbz <= (i_op == OP_DIV) && (i_b == '0);
    end else if (r_state == BUSY) begin
      r_cnt <= r_cnt + 6'd1;
      r_hi <= r_div ? (w_ge ? w_diff[W-1:0] : w_rem[W-1:0]) : w_sum[W:1];
      r_lo <= r_div ? {r_lo[W-2:0], w_ge} : {w_sum[0], r_lo[W-1:1]};
    end
  assign o_result = o_out_valid ? {r_hi, r_lo} : '0;
  assign o_carry = o_out_valid && r_carry;
  assign o_dbz = o_out_valid && r_dbz;
  assign o_zero = ~|o_result;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench driving a W=8 and a W=4 seq_alu against an arithmetic model.
module tb_seq_alu;
  typedef struct {
    longint res;
    bit     c;
    bit     dbz;
    int     lat;
    int     acc;
    bit     seen;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rstn, iv, ordy, ir, ov, cy, zr, dz;
  logic [3:0] op_i[2];
  logic [7:0] a_i[2], b_i[2];
  logic [15:0] r8;
  logic [7:0] r4;
  int cyc = 0;
  int checks = 0, errors = 0;
  bit rand_bp = 1'b0;
  bit hold_off[2];
  exp_t q[2][$];

  always @(posedge clk) cyc <= cyc + 1;

  seq_alu #(.W(8)) u8 (
    .clk(clk), .rst_n(rstn[0]), .i_in_valid(iv[0]), .o_in_ready(ir[0]),
    .i_a(a_i[0]), .i_b(b_i[0]), .i_op(op_i[0]), .o_out_valid(ov[0]),
    .i_out_ready(ordy[0]), .o_result(r8), .o_carry(cy[0]), .o_zero(zr[0]), .o_dbz(dz[0]));

  seq_alu #(.W(4)) u4 (
    .clk(clk), .rst_n(rstn[1]), .i_in_valid(iv[1]), .o_in_ready(ir[1]),
    .i_a(a_i[1][3:0]), .i_b(b_i[1][3:0]), .i_op(op_i[1]), .o_out_valid(ov[1]),
    .i_out_ready(ordy[1]), .o_result(r4), .o_carry(cy[1]), .o_zero(zr[1]), .o_dbz(dz[1]));

  function automatic logic [63:0] get_res(int d);
    return d == 0 ? 64'(r8) : 64'(r4);
  endfunction

  task automatic chk(string nm, int d, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h, want %0h", nm, d, act, exp);
    end
  endtask

  // Reference behaviour written directly from the operation definitions.
  function automatic exp_t model(int w, logic [3:0] op, longint a, longint b);
    exp_t e;
    longint m = (longint'(1) << w) - 1;
    e = '{default: 0};
    e.lat = 1;
    case (op)
      4'h0: begin e.res = (a + b) & m; e.c = ((a + b) >> w) != 0; end
      4'h1: begin e.res = (a - b) & m; e.c = a < b; end
      4'h2: begin e.res = a * b; e.lat = w + 1; end
      4'h3: begin
        e.lat = w + 1;
        if (b == 0) begin e.res = (a << w) | m; e.dbz = 1'b1; end
        else e.res = ((a % b) << w) | (a / b);
      end
      4'h4: begin e.res = (a << 1) & m; e.c = ((a >> (w - 1)) & 1) != 0; end
      4'h5: begin e.res = a >> 1; e.c = (a & 1) != 0; end
      4'h6: e.res = ((a << 1) | (a >> (w - 1))) & m;
      4'h7: e.res = ((a >> 1) | (a << (w - 1))) & m;
      4'h8: e.res = a & b;
      4'h9: e.res = a | b;
      4'hA: e.res = a ^ b;
      4'hB: e.res = ~(a | b) & m;
      4'hC: e.res = ~(a & b) & m;
      4'hD: e.res = ~(a ^ b) & m;
      4'hE: e.res = (a > b) ? 1 : 0;
      4'hF: e.res = (a == b) ? 1 : 0;
    endcase
    return e;
  endfunction

  // Monitor: while a result is presented its fields must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) if (rstn[d]) begin
      chk("in_ready", d, 64'(ir[d]), 64'(q[d].size() == 0));
      if (ov[d]) begin
        if (q[d].size() == 0) chk("out_valid_unexpected", d, 64'(ov[d]), 64'd0);
        else begin
          e = q[d][0];
          if (!e.seen) begin
            chk("latency", d, 64'(cyc - e.acc + 1), 64'(e.lat));
            e.seen = 1'b1;
            q[d][0] = e;
          end
          chk("result", d, get_res(d), e.res);
          chk("carry", d, 64'(cy[d]), 64'(e.c));
          chk("zero", d, 64'(zr[d]), 64'(e.res == 0));
          chk("dbz", d, 64'(dz[d]), 64'(e.dbz));
          if (ordy[d]) void'(q[d].pop_front());
        end
      end
    end
  end

  initial begin
    ordy = '1;
    forever begin
      @(posedge clk);
      #2;
      for (int d = 0; d < 2; d++)
        ordy[d] = !hold_off[d] && (!rand_bp || $urandom_range(3) != 0);
    end
  end

  task automatic issue(int d, logic [3:0] op, logic [7:0] a, logic [7:0] b);
    int w = d == 0 ? 8 : 4;
    int n = 0;
    logic [7:0] m = d == 0 ? 8'hFF : 8'h0F;
    exp_t e;
    @(negedge clk);
    while (!ir[d] && n < 100) begin @(negedge clk); n++; end
    if (!ir[d]) begin chk("accept_timeout", d, 64'(ir[d]), 64'd1); return; end
    iv[d] = 1'b1;
    op_i[d] = op;
    a_i[d] = a & m;
    b_i[d] = b & m;
    @(posedge clk);
    #1;
    e = model(w, op, longint'(a & m), longint'(b & m));
    e.acc = cyc;
    q[d].push_back(e);
    iv[d] = 1'b0;
    op_i[d] = 4'($urandom);
    a_i[d] = 8'($urandom);
    b_i[d] = 8'($urandom);
  endtask

  task automatic drain(int d);
    int n = 0;
    while (q[d].size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (q[d].size() != 0) chk("drain_timeout", d, 64'(q[d].size()), 64'd0);
  endtask

  task automatic chk_reset(int d);
    chk("rst_in_ready", d, 64'(ir[d]), 64'd1);
    chk("rst_out_valid", d, 64'(ov[d]), 64'd0);
    chk("rst_result", d, get_res(d), 64'd0);
    chk("rst_carry", d, 64'(cy[d]), 64'd0);
    chk("rst_zero", d, 64'(zr[d]), 64'd1);
    chk("rst_dbz", d, 64'(dz[d]), 64'd0);
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(5))
      0: return 8'h00;
      1: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = '1;
    iv = '0;
    hold_off[0] = 1'b0;
    hold_off[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin op_i[d] = '0; a_i[d] = '0; b_i[d] = '0; end
    #1 rstn = '0;
    #1;
    chk_reset(0);
    chk_reset(1);
    @(posedge clk);
    @(posedge clk);
    #2 rstn = '1;
    issue(0, 4'h0, 8'hF0, 8'h20);
    issue(0, 4'h2, 8'hFF, 8'hFF);
    issue(0, 4'h3, 8'd200, 8'd7);
    issue(0, 4'h3, 8'h55, 8'h00);
    drain(0);
    hold_off[0] = 1'b1;
    issue(0, 4'h1, 8'd3, 8'd5);
    repeat (6) @(negedge clk);
    hold_off[0] = 1'b0;
    drain(0);
    issue(0, 4'h2, pick(), pick());
    repeat (3) @(posedge clk);
    #3 rstn[0] = 1'b0;
    #1;
    chk_reset(0);
    q[0].delete();
    @(posedge clk);
    #2 rstn[0] = 1'b1;
    issue(0, 4'hF, 8'd9, 8'd9);
    drain(0);
    rand_bp = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 8; r++)
        for (int op = 0; op < 16; op++) issue(d, 4'(op), pick(), pick());
      drain(d);
    end
    rand_bp = 1'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
